// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC sequencer states and flush/PC-step constants.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } seq_state_e;

    localparam int PC_INC = 4;

    // A flush turns the stage register's contents into a NOP bubble.
    localparam logic FLUSH_BUBBLE = 1'b1;

endpackage

// File: rtl/pc_seq_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: owns the fetch PC and drives IF/ID, ID/EX enables and flushes,
// with a RUN/DRAIN/HALTED machine so older instructions retire before a halt.
module pc_seq_ctrl
    import pipe_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int DRAIN_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             halt_req,
    input  logic [31:0]      halt_pc,
    input  logic             restart,
    output logic [PC_W-1:0]  pc,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic             target_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int DC_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

    seq_state_e       state;
    logic [DC_W-1:0]  drain_cnt;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  redir_pc;
    logic             bad_target;
    logic             take_redirect;
    logic             unused_hi;

    assign pc_inc        = pc + PC_W'(PC_INC);
    assign redir_pc      = {redirect_pc[PC_W-1:2], 2'b00};
    assign bad_target    = (redirect_pc[1:0] != 2'b00) || (redirect_pc[31:PC_W] != '0);
    assign take_redirect = (state == RUN) && !halt_req && redirect_valid;
    assign unused_hi     = ^halt_pc[31:PC_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            state      <= RUN;
            drain_cnt  <= '0;
            target_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        pc        <= halt_pc[PC_W-1:0];
                        drain_cnt <= DC_W'(DRAIN_CYC);
                        state     <= (DRAIN_CYC == 0) ? HALTED : DRAIN;
                    end else if (redirect_valid) begin
                        // EX is older than the ID hazard, so a coincident stall is dropped.
                        pc <= redir_pc;
                        if (bad_target)
                            target_err <= 1'b1;
                    end else if (!stall) begin
                        pc <= pc_inc;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - DC_W'(1);
                    if (drain_cnt == DC_W'(1))
                        state <= HALTED;
                end
                HALTED: begin
                    if (restart) begin
                        pc    <= pc_inc;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (halt_req || redirect_valid) begin
                        if_id_flush = FLUSH_BUBBLE;
                        id_ex_flush = FLUSH_BUBBLE;
                    end else if (stall) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = FLUSH_BUBBLE;
                    end
                end
                DRAIN, HALTED: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    if_id_flush = FLUSH_BUBBLE;
                    id_ex_flush = FLUSH_BUBBLE;
                    halted      = (state == HALTED);
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (take_redirect),
        .count (redirect_cnt)
    );

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: per-cycle control checks plus a next-PC scoreboard.
module tb_pc_seq_ctrl;

    localparam logic [3:0] CTL_RUN = 4'b1100;  // {pc_en, if_id_en, if_id_flush, id_ex_flush}
    localparam logic [3:0] CTL_FL  = 4'b1111;
    localparam logic [3:0] CTL_ST  = 4'b0001;
    localparam logic [3:0] CTL_OFF = 4'b0011;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, halt_req, restart;
    logic [31:0] redirect_pc, halt_pc;
    logic [8:0]  pc;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, halted, target_err;
    logic [1:0]  redirect_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    pc_seq_ctrl #(.PC_W(9), .DRAIN_CYC(2), .CNT_W(2)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halt_pc        (halt_pc),
        .restart        (restart),
        .pc             (pc),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .halted         (halted),
        .target_err     (target_err),
        .redirect_cnt   (redirect_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle, check controls mid-cycle, then score the PC after the edge.
    task automatic cyc(input string tag, input logic s, input logic rv, input logic [31:0] rpc,
                       input logic hr, input logic [31:0] hpc, input logic rs,
                       input logic [3:0] ctl, input logic hl, input logic [8:0] npc);
        stall = s; redirect_valid = rv; redirect_pc = rpc;
        halt_req = hr; halt_pc = hpc; restart = rs;
        @(negedge clk);
        chk({tag, "_ctl"}, 32'({pc_en, if_id_en, if_id_flush, id_ex_flush}), 32'(ctl));
        chk({tag, "_halted"}, 32'(halted), 32'(hl));
        exp_q.push_back(npc);
        @(posedge clk); #1;
        chk({tag, "_pc"}, 32'(pc), 32'(exp_q.pop_front()));
    endtask

    task automatic idle(input string tag, input logic [3:0] ctl, input logic hl, input logic [8:0] npc);
        cyc(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, ctl, hl, npc);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        halt_req = 1'b0; halt_pc = 32'h0; restart = 1'b0;
        @(negedge clk);
        chk("rst_ctl", 32'({pc_en, if_id_en, if_id_flush, id_ex_flush}), 32'(CTL_RUN));
        chk("rst_halted_comb", 32'(halted), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_cnt", 32'(redirect_cnt), 32'h0);
        chk("rst_err", 32'(target_err), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        halt_req = 1'b0; halt_pc = 32'h0; restart = 1'b0;
        @(posedge clk); #1;
        do_reset();

        for (int i = 0; i < 8; i++)
            idle("seq", CTL_RUN, 1'b0, 9'(4 * (i + 1)));

        cyc("redir_stall", 1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, CTL_FL, 1'b0, 9'h080);
        chk("cnt_1", 32'(redirect_cnt), 32'h1);
        chk("err_0", 32'(target_err), 32'h0);
        cyc("redir_40", 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, CTL_FL, 1'b0, 9'h040);
        cyc("stall_a", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, CTL_ST, 1'b0, 9'h040);
        cyc("stall_b", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, CTL_ST, 1'b0, 9'h040);
        idle("post_stall", CTL_RUN, 1'b0, 9'h044);

        cyc("halt", 1'b0, 1'b1, 32'h100, 1'b1, 32'h30, 1'b0, CTL_FL, 1'b0, 9'h030);
        chk("cnt_halt", 32'(redirect_cnt), 32'h2);
        cyc("drain_1", 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, CTL_OFF, 1'b0, 9'h030);
        cyc("drain_2", 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, CTL_OFF, 1'b0, 9'h030);
        cyc("halted", 1'b0, 1'b1, 32'h100, 1'b1, 32'h60, 1'b0, CTL_OFF, 1'b1, 9'h030);
        chk("cnt_halted", 32'(redirect_cnt), 32'h2);
        cyc("restart", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, CTL_OFF, 1'b1, 9'h034);
        idle("resume", CTL_RUN, 1'b0, 9'h038);

        cyc("bad_tgt", 1'b0, 1'b1, 32'h202, 1'b0, 32'h0, 1'b0, CTL_FL, 1'b0, 9'h000);
        chk("err_set", 32'(target_err), 32'h1);
        chk("cnt_3", 32'(redirect_cnt), 32'h3);
        cyc("mis_tgt", 1'b0, 1'b1, 32'h1FE, 1'b0, 32'h0, 1'b0, CTL_FL, 1'b0, 9'h1FC);
        chk("cnt_sat_a", 32'(redirect_cnt), 32'h3);
        idle("wrap", CTL_RUN, 1'b0, 9'h000);
        chk("err_sticky", 32'(target_err), 32'h1);

        do_reset();
        for (int i = 0; i < 5; i++)
            cyc("sat", 1'b0, 1'b1, 32'(16 * (i + 1)), 1'b0, 32'h0, 1'b0, CTL_FL, 1'b0, 9'(16 * (i + 1)));
        chk("cnt_sat_b", 32'(redirect_cnt), 32'h3);
        chk("err_clean", 32'(target_err), 32'h0);

        cyc("halt2", 1'b0, 1'b0, 32'h0, 1'b1, 32'h50, 1'b0, CTL_FL, 1'b0, 9'h050);
        idle("drain_x", CTL_OFF, 1'b0, 9'h050);
        do_reset();
        idle("post_rst", CTL_RUN, 1'b0, 9'h004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
